// File: rtl/bus_master_if_pkg.sv
// Shared bus definitions: active-low strobe levels, direction codes, word
// widths, slave-select field position and the master interface state encoding.
package bus_master_if_pkg;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;

  localparam int WORD_ADDR_W = 30;
  localparam int WORD_DATA_W = 32;

  // Top three word-address bits pick one of the eight slaves.
  localparam int SLV_IDX_W   = 3;
  localparam int SLV_IDX_MSB = WORD_ADDR_W - 1;
  localparam int SLV_IDX_LSB = WORD_ADDR_W - SLV_IDX_W;

  typedef enum logic [1:0] {
    BUS_IF_IDLE   = 2'd0,
    BUS_IF_REQ    = 2'd1,
    BUS_IF_ACCESS = 2'd2,
    BUS_IF_STALL  = 2'd3
  } bus_if_state_e;

  function automatic logic [SLV_IDX_W-1:0] slave_idx(input logic [WORD_ADDR_W-1:0] addr);
    return addr[SLV_IDX_MSB:SLV_IDX_LSB];
  endfunction

endpackage

// File: rtl/bus_master_if_tmo.sv
// Ready-timeout counter: cleared when the address strobe is issued, counts
// every ACCESS cycle and flags the last cycle the slave is allowed to take.
module bus_tmo_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/bus_master_if.sv
// Initiator side of one master slot: request/grant/strobe/ready handshake,
// transaction latching, read-data return and a ready-timeout abort.
module bus_master_if
  import bus_master_if_pkg::*;
#(
  parameter int ADDR_W  = WORD_ADDR_W,
  parameter int DATA_W  = WORD_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              core_as_,
  input  logic              core_rw,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wr_data,
  output logic [DATA_W-1:0] core_rd_data,
  output logic              busy,
  output logic              err,
  output logic              bus_req_,
  input  logic              bus_grnt_,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_
);

  bus_if_state_e     state_q, state_d;
  logic              req_q, req_d;
  logic              as_q, as_d;
  logic              rw_q, rw_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd_buf_q, rd_buf_d;
  logic              tmo_clr, tmo_en, tmo_tc;

  bus_tmo_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk   (clk),
    .reset (reset),
    .clr   (tmo_clr),
    .en    (tmo_en),
    .tc    (tmo_tc)
  );

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    as_d         = DISABLE_;
    rw_d         = rw_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_buf_d     = rd_buf_q;
    err_d        = 1'b0;
    tmo_clr      = 1'b0;
    tmo_en       = 1'b0;
    busy         = 1'b0;
    core_rd_data = rd_buf_q;

    case (state_q)
      BUS_IF_IDLE: begin
        busy = (core_as_ == ENABLE_) && !flush;
        if (busy) begin
          addr_d  = core_addr;
          rw_d    = core_rw;
          wdata_d = core_wr_data;
          req_d   = ENABLE_;
          state_d = BUS_IF_REQ;
        end
      end
      BUS_IF_REQ: begin
        busy = 1'b1;
        if (bus_grnt_ == ENABLE_) begin
          as_d    = ENABLE_;
          tmo_clr = 1'b1;
          state_d = BUS_IF_ACCESS;
        end
      end
      BUS_IF_ACCESS: begin
        tmo_en = 1'b1;
        // Ready is checked first so a reply on the last allowed cycle still wins.
        if (bus_rdy_ == ENABLE_) begin
          if (rw_q == READ) begin
            rd_buf_d     = bus_rd_data;
            core_rd_data = bus_rd_data;
          end
          req_d   = DISABLE_;
          state_d = stall ? BUS_IF_STALL : BUS_IF_IDLE;
        end else if (tmo_tc) begin
          req_d    = DISABLE_;
          err_d    = 1'b1;
          rd_buf_d = '0;
          state_d  = stall ? BUS_IF_STALL : BUS_IF_IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      BUS_IF_STALL: begin
        if (!stall) state_d = BUS_IF_IDLE;
      end
      default: state_d = BUS_IF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= BUS_IF_IDLE;
      req_q    <= DISABLE_;
      as_q     <= DISABLE_;
      rw_q     <= READ;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_buf_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      as_q     <= as_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_buf_q <= rd_buf_d;
      err_q    <= err_d;
    end
  end

  assign bus_req_    = req_q;
  assign bus_as_     = as_q;
  assign bus_rw      = rw_q;
  assign bus_addr    = addr_q;
  assign bus_wr_data = wdata_q;
  assign err         = err_q;

endmodule

// File: tb/tb_bus_master_if.sv
// Randomized bench for bus_master_if: the driver plays core and bus, pushes the
// expected strobe and completion of each access; a monitor pops and compares.
module tb_bus_master_if;
  import bus_master_if_pkg::*;

  localparam int AW  = 30;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          reset, stall, flush, core_as_, core_rw;
  logic [AW-1:0] core_addr, bus_addr;
  logic [DW-1:0] core_wr_data, core_rd_data, bus_wr_data, bus_rd_data;
  logic          busy, err, bus_req_, bus_grnt_, bus_as_, bus_rw, bus_rdy_;

  bus_master_if #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .core_as_(core_as_), .core_rw(core_rw), .core_addr(core_addr),
    .core_wr_data(core_wr_data), .core_rd_data(core_rd_data), .busy(busy),
    .err(err), .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_addr(bus_addr),
    .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [AW-1:0] addr; logic rw; logic [DW-1:0] wd; } strb_t;
  typedef struct { int end_cyc; bit tmo; logic rw; logic [DW-1:0] rd; logic [DW-1:0] rb; } done_t;

  strb_t sq[$];
  done_t dq[$];
  int nchk = 0;
  int nerr = 0;
  logic [DW-1:0] model_buf = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    nchk++;
    nerr++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // One core access. g: REQ cycles before grant; r: ACCESS cycle of ready
  // (>= TMO means the slave never answers); s: stall cycles after completion.
  task automatic txn(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                     input int g, input int r, input logic [DW-1:0] rd, input int s);
    int    a, acc;
    bit    tmo;
    strb_t e;
    done_t d;
    a   = cyc;
    tmo = (r >= TMO);
    acc = tmo ? TMO - 1 : r;
    core_as_ = ENABLE_; core_rw = rw; core_addr = addr; core_wr_data = wd;
    flush = 1'b0; stall = 1'b0; bus_grnt_ = DISABLE_;
    bus_rdy_ = 1'($urandom); bus_rd_data = $urandom;
    if (tmo)             model_buf = '0;
    else if (rw == READ) model_buf = rd;
    e.cyc = a + 2 + g; e.addr = addr; e.rw = rw; e.wd = wd;
    sq.push_back(e);
    d.end_cyc = a + 2 + g + acc; d.tmo = tmo; d.rw = rw; d.rd = rd; d.rb = model_buf;
    dq.push_back(d);
    @(posedge clk); #1;
    for (int k = 0; k <= g; k++) begin
      bus_grnt_ = (k == g) ? ENABLE_ : DISABLE_;
      bus_rdy_ = 1'($urandom); bus_rd_data = $urandom; flush = 1'($urandom);
      core_addr = AW'($urandom); core_wr_data = $urandom; core_rw = 1'($urandom);
      @(posedge clk); #1;
    end
    for (int j = 0; j <= acc; j++) begin
      bus_grnt_ = 1'($urandom);
      bus_rdy_ = (j == r) ? ENABLE_ : DISABLE_;
      bus_rd_data = (j == r) ? rd : $urandom;
      stall = (j == acc) && (s > 0);
      flush = 1'($urandom); core_addr = AW'($urandom); core_rw = 1'($urandom);
      @(posedge clk); #1;
    end
    bus_rdy_ = DISABLE_; bus_grnt_ = DISABLE_; flush = 1'b0;
    for (int i = 1; i <= s; i++) begin
      stall = (i < s);
      core_as_ = ENABLE_; core_addr = AW'($urandom); core_rw = 1'($urandom);
      bus_rdy_ = 1'($urandom); bus_rd_data = $urandom;
      @(posedge clk); #1;
    end
    core_as_ = DISABLE_; stall = 1'b0;
  endtask

  // Idle cycles: requests are either absent or flushed, so nothing may start.
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      core_as_ = 1'($urandom); flush = 1'b1; core_addr = AW'($urandom);
      bus_rdy_ = 1'($urandom); bus_grnt_ = 1'($urandom);
      @(negedge clk);
      chk("flush_busy", 64'(busy), 64'(0));
      chk("flush_req", 64'(bus_req_), 64'(DISABLE_));
      @(posedge clk); #1;
    end
    flush = 1'b0; core_as_ = DISABLE_; bus_grnt_ = DISABLE_; bus_rdy_ = DISABLE_;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},  64'(bus_req_), 64'(DISABLE_));
    chk({tag, "_as"},   64'(bus_as_), 64'(DISABLE_));
    chk({tag, "_rw"},   64'(bus_rw), 64'(READ));
    chk({tag, "_addr"}, 64'(bus_addr), 64'(0));
    chk({tag, "_wd"},   64'(bus_wr_data), 64'(0));
    chk({tag, "_rd"},   64'(core_rd_data), 64'(0));
    chk({tag, "_err"},  64'(err), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  // Monitor: strobe contents/timing, completion timing, err pulse, read data.
  initial begin
    strb_t e;
    done_t d;
    logic [DW-1:0] exp_buf, exp_now;
    logic prev_req, prev_as;
    exp_buf = '0; prev_req = DISABLE_; prev_as = DISABLE_;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_buf = '0; prev_req = DISABLE_; prev_as = DISABLE_;
        continue;
      end
      if (bus_as_ == ENABLE_) begin
        chk("as_width", 64'(prev_as), 64'(DISABLE_));
        if (sq.size() == 0) fail("strobe_unexpected");
        else begin
          e = sq.pop_front();
          chk("strobe_cyc", 64'(cyc), 64'(e.cyc));
          chk("strobe_addr", 64'(bus_addr), 64'(e.addr));
          chk("strobe_rw", 64'(bus_rw), 64'(e.rw));
          if (e.rw == WRITE) chk("strobe_wd", 64'(bus_wr_data), 64'(e.wd));
        end
      end
      exp_now = exp_buf;
      if (prev_req == ENABLE_ && bus_req_ == DISABLE_) begin
        if (dq.size() == 0) fail("release_unexpected");
        else begin
          d = dq.pop_front();
          chk("release_cyc", 64'(cyc), 64'(d.end_cyc + 1));
          chk("err_pulse", 64'(err), 64'(d.tmo));
          exp_buf = d.rb;
          exp_now = d.rb;
        end
      end else if (err) fail("err_spurious");
      if (dq.size() > 0) begin
        if (cyc == dq[0].end_cyc) begin
          chk("busy_done", 64'(busy), 64'(0));
          if (dq[0].rw == READ && !dq[0].tmo) exp_now = dq[0].rd;
        end else if (cyc < dq[0].end_cyc) chk("busy_hold", 64'(busy), 64'(1));
      end
      chk("rd_data", 64'(core_rd_data), 64'(exp_now));
      prev_req = bus_req_;
      prev_as  = bus_as_;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int g, r, s;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; core_as_ = DISABLE_; core_rw = READ;
    core_addr = '0; core_wr_data = '0; bus_grnt_ = DISABLE_; bus_rdy_ = DISABLE_;
    bus_rd_data = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk_reset_vals("rst");
    @(posedge clk); #1;
    reset = 1'b0;

    txn(READ,  30'h0800_0010, 32'h0, 0, 0, 32'h1, 0);          // zero-wait read
    txn(WRITE, 30'h1234_5678, 32'hDEAD_BEEF, 4, 2, 32'h55, 0); // contended write
    txn(READ,  30'h2000_0040, 32'h0, 1, 99, 32'hAA, 0);        // slave absent
    txn(READ,  30'h0000_0004, 32'h0, 0, TMO - 1, 32'h5, 0);    // ready on last cycle
    txn(READ,  30'h3000_0008, 32'h0, 0, 1, 32'h3, 5);          // stall hold
    gap(3);

    for (int n = 0; n < 40; n++) begin
      g = $urandom_range(0, 3);
      r = $urandom_range(0, 19);
      s = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      txn(1'($urandom), AW'($urandom), $urandom, g, r, $urandom, s);
      gap($urandom_range(0, 2));
    end

    // Reset while waiting for grant releases everything on the next edge.
    core_as_ = ENABLE_; core_rw = WRITE; core_addr = 30'h1555_5555;
    core_wr_data = 32'hCAFE_F00D; bus_grnt_ = DISABLE_;
    @(posedge clk); #1;
    core_as_ = DISABLE_;
    @(negedge clk);
    chk("pre_rst_req", 64'(bus_req_), 64'(ENABLE_));
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk_reset_vals("midrst");
    @(posedge clk); #1;
    reset = 1'b0;
    model_buf = '0;

    txn(READ, 30'h0400_0001, 32'h0, 0, 0, 32'h7777_0001, 0);
    gap(4);
    chk("sq_empty", 64'(sq.size()), 64'(0));
    chk("dq_empty", 64'(dq.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
